simon_seq_engine: RTL and testbench
===================================

Name: simon_seq_engine

Overview:
Parametrised Simon game engine for the 60 Hz game tick domain. It stores a growing random key sequence of up to MAX_LEN entries and plays it back with programmable on/off timing. It then checks the player's presses against the stored sequence, with a per-press timeout. It drives the display/sound front-end and reports score, loss and win to the top-level game controller.

Parameters:
NUM_KEYS, 4, number of distinct keys/lamps (2..2**KEY_W)
KEY_W, 2, key index width
MAX_LEN, 32, sequence length that counts as a win (2..256)
LEN_W, 6, width of length/score outputs, must hold MAX_LEN
ON_TICKS, 30, clk cycles a lamp is lit during playback
OFF_TICKS, 15, clk cycles dark between playback lamps
TIMEOUT_TICKS, 300, max clk cycles waiting for a player press

Ports:
clk  in  1  game tick clock (60 Hz)
reset  in  1  asynchronous, active-high
start  in  1  begin new game; accepted in IDLE, LOSE, WIN only
rand  in  KEY_W  free-running random source
player_key  in  KEY_W  key currently selected by player
player_press  in  1  level, high while player holds a key
simon_turn  out  1  high while engine appends or plays back
simon_key  out  KEY_W  key being shown
simon_pressed  out  1  lamp on
seq_len  out  LEN_W  current sequence length
score  out  LEN_W  rounds fully completed this game
game_over  out  1  high in LOSE
win  out  1  high in WIN

Behaviour:
- Reset: state IDLE. All outputs are 0, length/index/timers are 0, and the armed flag is cleared. Memory contents are don't-care.
- IDLE: wait for start=1, then clear seq_len, score and idx, and go to APPEND.
- APPEND (simon_turn=1):
  - If rand < NUM_KEYS, write mem[seq_len] <= rand, increment seq_len, set idx=0, load timer=ON_TICKS, go to SHOW_ON.
  - Otherwise stay in APPEND (reject out-of-range values, no modulo bias).
- SHOW_ON (simon_turn=1): simon_pressed=1, simon_key=mem[idx]. When the timer expires after exactly ON_TICKS cycles, load OFF_TICKS and go to SHOW_OFF.
- SHOW_OFF (simon_turn=1): simon_pressed=0, simon_key holds its value. When the timer expires:
  - If idx==seq_len-1: set idx=0, load TIMEOUT_TICKS, clear armed, go to WAIT_PRESS.
  - Else: increment idx, load ON_TICKS, go to SHOW_ON.
- WAIT_PRESS (simon_turn=0):
  - armed sets on the first cycle player_press=0. A key held over from before the player's turn is ignored until it is released.
  - With armed=1 and player_press=1: compare player_key to mem[idx]. On mismatch go to LOSE. On match go to WAIT_RELEASE.
  - The timer decrements every cycle. On expiry go to LOSE. A press and the expiry in the same cycle count as a valid press.
- WAIT_RELEASE: wait for player_press=0. There is no timeout in this state.
  - If idx==seq_len-1: increment score. If seq_len==MAX_LEN go to WIN, else go to APPEND.
  - Else: increment idx, reload TIMEOUT_TICKS, go to WAIT_PRESS (armed stays set).
- LOSE: game_over=1, hold until start. WIN: win=1, hold until start. On start from either, clear game_over/win and act as in IDLE.
- start in any other state is ignored. An asynchronous reset mid-playback or mid-input returns to IDLE within the same edge, with outputs zero.
- All outputs are registered, so there is one cycle of latency from a state change to its outputs.
- Counters are unsigned. seq_len never exceeds MAX_LEN, and score never exceeds MAX_LEN.

Decomposition:
- Package simon_pkg: state enum (IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_PRESS, WAIT_RELEASE, LOSE, WIN) and the default timing localparams.
- Sub-module simon_tick_timer: a loadable down-counter with load value, load strobe and expired flag, used for the ON, OFF and TIMEOUT phases.
- The sequence memory is a register array inside the engine.

Test Plan:
- Assert reset mid-SHOW_ON -> all outputs 0 the same edge and state IDLE. start then gives seq_len=1, and simon_pressed stays high for exactly 30 cycles.
- With rand forced to 3 and then 1, complete rounds 1 and 2 correctly -> playback shows 3 then 3,1. score steps 0→1→2 and game_over stays 0.
- In round 2, press key 2 when 1 is expected -> game_over=1 one cycle later, and later presses are ignored.
- Hold player_press=1 across the end of playback, then release and press the correct key -> the held press is ignored and the correct press is accepted.
- Make no press for 300 cycles -> game_over=1. A correct press exactly at cycle 300 -> accepted.
- Use MAX_LEN=4 and NUM_KEYS=3, with rand cycling through 3 (rejected), 0, 1, 2, 0. Play all rounds correctly -> value 3 is never stored, win=1, score=4. start then returns to seq_len=1 with win cleared.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game engine: FSM state encoding and default timing.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPEND,
    SHOW_ON,
    SHOW_OFF,
    WAIT_PRESS,
    WAIT_RELEASE,
    LOSE,
    WIN
  } state_e;

  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_KEY_W         = 2;
  localparam int DEF_MAX_LEN       = 32;
  localparam int DEF_LEN_W         = 6;
  localparam int DEF_ON_TICKS      = 30;
  localparam int DEF_OFF_TICKS     = 15;
  localparam int DEF_TIMEOUT_TICKS = 300;

  // Wide enough for any of the three phase durations.
  localparam int TIMER_W = 16;

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable down-counter; o_expired is high during the last cycle of a loaded
// period, so a load of N keeps its owner in a phase for exactly N cycles.
module simon_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == W'(1));

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game engine: grows a random key sequence, plays it back with timed
// lamps, then checks the player's presses against it with a per-press timeout.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int KEY_W         = DEF_KEY_W,
  parameter int MAX_LEN       = DEF_MAX_LEN,
  parameter int LEN_W         = DEF_LEN_W,
  parameter int ON_TICKS      = DEF_ON_TICKS,
  parameter int OFF_TICKS     = DEF_OFF_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_rand,
  input  logic [KEY_W-1:0] i_player_key,
  input  logic             i_player_press,
  output logic             o_simon_turn,
  output logic [KEY_W-1:0] o_simon_key,
  output logic             o_simon_pressed,
  output logic [LEN_W-1:0] o_seq_len,
  output logic [LEN_W-1:0] o_score,
  output logic             o_game_over,
  output logic             o_win
);

  localparam int ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  localparam logic [KEY_W:0]   NUM_KEYS_V = (KEY_W + 1)'(NUM_KEYS);
  localparam logic [LEN_W-1:0] MAX_LEN_V  = LEN_W'(MAX_LEN);

  state_e r_state, w_next_state;

  logic [KEY_W-1:0] r_mem [MEM_DEPTH];
  logic [LEN_W-1:0] r_seq_len;
  logic [LEN_W-1:0] r_score;
  logic [LEN_W-1:0] r_idx;
  logic             r_armed;

  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  logic               w_tmr_expired;

  logic w_new_game;
  logic w_append;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_score_inc;
  logic w_arm_clr;

  logic             w_rand_ok;
  logic             w_idx_last;
  logic [KEY_W-1:0] w_exp_key;

  // Out-of-range random values are rejected rather than folded, avoiding bias.
  assign w_rand_ok  = ({1'b0, i_rand} < NUM_KEYS_V);
  assign w_idx_last = (r_idx == r_seq_len - LEN_W'(1));
  assign w_exp_key  = r_mem[r_idx[ADDR_W-1:0]];

  simon_tick_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_new_game   = 1'b0;
    w_append     = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_score_inc  = 1'b0;
    w_arm_clr    = 1'b0;

    case (r_state)
      IDLE, LOSE, WIN: begin
        if (i_start) begin
          w_new_game   = 1'b1;
          w_next_state = APPEND;
        end
      end

      APPEND: begin
        if (w_rand_ok) begin
          w_append     = 1'b1;
          w_idx_clr    = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TIMER_W'(ON_TICKS);
          w_next_state = SHOW_ON;
        end
      end

      SHOW_ON: begin
        if (w_tmr_expired) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = TIMER_W'(OFF_TICKS);
          w_next_state = SHOW_OFF;
        end
      end

      SHOW_OFF: begin
        if (w_tmr_expired) begin
          w_tmr_load = 1'b1;
          if (w_idx_last) begin
            w_idx_clr    = 1'b1;
            w_arm_clr    = 1'b1;
            w_tmr_val    = TIMER_W'(TIMEOUT_TICKS);
            w_next_state = WAIT_PRESS;
          end else begin
            w_idx_inc    = 1'b1;
            w_tmr_val    = TIMER_W'(ON_TICKS);
            w_next_state = SHOW_ON;
          end
        end
      end

      WAIT_PRESS: begin
        // A valid press takes priority over a timeout in the same cycle.
        if (r_armed && i_player_press) begin
          w_next_state = (i_player_key == w_exp_key) ? WAIT_RELEASE : LOSE;
        end else if (w_tmr_expired) begin
          w_next_state = LOSE;
        end
      end

      WAIT_RELEASE: begin
        if (!i_player_press) begin
          if (w_idx_last) begin
            w_score_inc  = 1'b1;
            w_next_state = (r_seq_len == MAX_LEN_V) ? WIN : APPEND;
          end else begin
            w_idx_inc    = 1'b1;
            w_tmr_load   = 1'b1;
            w_tmr_val    = TIMER_W'(TIMEOUT_TICKS);
            w_next_state = WAIT_PRESS;
          end
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq_len <= '0;
      r_score   <= '0;
      r_idx     <= '0;
      r_armed   <= 1'b0;
    end else if (w_new_game) begin
      r_seq_len <= '0;
      r_score   <= '0;
      r_idx     <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (w_append) begin
        r_seq_len <= r_seq_len + LEN_W'(1);
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + LEN_W'(1);
      end
      if (w_score_inc) begin
        r_score <= r_score + LEN_W'(1);
      end
      // A key still held from before the player's turn must be released first.
      if (w_arm_clr) begin
        r_armed <= 1'b0;
      end else if (r_state == WAIT_PRESS && !i_player_press) begin
        r_armed <= 1'b1;
      end
    end
  end

  // NOTE: the sequence memory has no reset; entries are always written before
  // they are read, and leaving it out keeps it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (w_append) begin
      r_mem[r_seq_len[ADDR_W-1:0]] <= i_rand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_simon_turn    <= 1'b0;
      o_simon_key     <= '0;
      o_simon_pressed <= 1'b0;
      o_seq_len       <= '0;
      o_score         <= '0;
      o_game_over     <= 1'b0;
      o_win           <= 1'b0;
    end else begin
      o_simon_turn    <= (r_state == APPEND) || (r_state == SHOW_ON) ||
                         (r_state == SHOW_OFF);
      o_simon_pressed <= (r_state == SHOW_ON);
      if (r_state == SHOW_ON) begin
        o_simon_key <= w_exp_key;
      end
      o_seq_len       <= r_seq_len;
      o_score         <= r_score;
      o_game_over     <= (r_state == LOSE);
      o_win           <= (r_state == WIN);
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine: a default instance and a small
// MAX_LEN=4 / NUM_KEYS=3 instance share stimulus; use_w selects which is observed.
module tb_simon_seq_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] rand_v;
  logic [1:0] player_key;
  logic       player_press;

  logic       d_turn, d_pressed, d_game_over, d_win;
  logic [1:0] d_key;
  logic [5:0] d_seq_len, d_score;
  logic       w_turn, w_pressed, w_game_over, w_win;
  logic [1:0] w_key;
  logic [5:0] w_seq_len, w_score;

  logic       use_w;
  logic       m_turn, m_pressed, m_game_over, m_win;
  logic [1:0] m_key;
  logic [5:0] m_seq_len, m_score;

  int total = 0;
  int bad   = 0;

  simon_seq_engine dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_rand          (rand_v),
    .i_player_key    (player_key),
    .i_player_press  (player_press),
    .o_simon_turn    (d_turn),
    .o_simon_key     (d_key),
    .o_simon_pressed (d_pressed),
    .o_seq_len       (d_seq_len),
    .o_score         (d_score),
    .o_game_over     (d_game_over),
    .o_win           (d_win)
  );

  simon_seq_engine #(
    .NUM_KEYS (3),
    .MAX_LEN  (4)
  ) dut_w (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_rand          (rand_v),
    .i_player_key    (player_key),
    .i_player_press  (player_press),
    .o_simon_turn    (w_turn),
    .o_simon_key     (w_key),
    .o_simon_pressed (w_pressed),
    .o_seq_len       (w_seq_len),
    .o_score         (w_score),
    .o_game_over     (w_game_over),
    .o_win           (w_win)
  );

  assign m_turn      = use_w ? w_turn      : d_turn;
  assign m_pressed   = use_w ? w_pressed   : d_pressed;
  assign m_game_over = use_w ? w_game_over : d_game_over;
  assign m_win       = use_w ? w_win       : d_win;
  assign m_key       = use_w ? w_key       : d_key;
  assign m_seq_len   = use_w ? w_seq_len   : d_seq_len;
  assign m_score     = use_w ? w_score     : d_score;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    player_press = 1'b0;
    player_key   = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the next lamp, then checks its key and its lit duration.
  task automatic wait_lamp(input logic [1:0] k);
    int n  = 0;
    int hi = 0;
    while (!m_pressed && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (m_pressed !== 1'b1) begin
      bad++;
      $display("FAIL lamp_start: pressed=%0b after %0d cycles, required 1", m_pressed, n);
    end else begin
      total++;
      if (m_key !== k) begin
        bad++;
        $display("FAIL lamp_key: key=%0d required %0d", m_key, k);
      end
      while (m_pressed && hi < 100) begin
        tick();
        hi++;
      end
      total++;
      if (hi !== 30) begin
        bad++;
        $display("FAIL lamp_len: lit %0d cycles, required 30", hi);
      end
    end
  endtask

  task automatic wait_player_turn();
    int n = 0;
    while (m_turn && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (m_turn !== 1'b0) begin
      bad++;
      $display("FAIL player_turn: simon_turn=%0b after %0d cycles, required 0", m_turn, n);
    end
  endtask

  task automatic play_key(input logic [1:0] k);
    player_key   = k;
    player_press = 1'b1;
    tick();
    player_press = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    use_w  = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    rand_v = 2'd1;
    player_press = 1'b0;
    player_key   = 2'd0;
    tick();
    outs = {d_turn, d_pressed, d_key, d_seq_len, d_score, d_game_over, d_win};
    total++;
    if (outs !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs: outputs=%h required 0", outs);
    end
    reset = 1'b0;
    tick();
    pulse_start();
    begin
      int n = 0;
      while (!m_pressed && n < 100) begin
        tick();
        n++;
      end
    end
    repeat (5) tick();
    total++;
    if (m_pressed !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_lamp: pressed=%0b required 1", m_pressed);
    end
    #2 reset = 1'b1;
    #1;
    outs = {d_turn, d_pressed, d_key, d_seq_len, d_score, d_game_over, d_win};
    total++;
    if (outs !== 18'd0) begin
      bad++;
      $display("FAIL midshow_reset: outputs=%h required 0", outs);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (m_turn !== 1'b0 || m_seq_len !== 6'd0) begin
      bad++;
      $display("FAIL idle_after_reset: turn=%0b seq_len=%0d required 0/0", m_turn, m_seq_len);
    end
    rand_v = 2'd2;
    pulse_start();
    wait_lamp(2'd2);
    total++;
    if (m_seq_len !== 6'd1) begin
      bad++;
      $display("FAIL restart_len: seq_len=%0d required 1", m_seq_len);
    end
  endtask

  task automatic test_rounds();
    use_w  = 1'b0;
    do_reset();
    rand_v = 2'd3;
    pulse_start();
    wait_lamp(2'd3);
    rand_v = 2'd1;
    total++;
    if (m_score !== 6'd0 || m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL round1_status: score=%0d game_over=%0b required 0/0", m_score, m_game_over);
    end
    wait_player_turn();
    play_key(2'd3);
    wait_lamp(2'd3);
    wait_lamp(2'd1);
    total++;
    if (m_score !== 6'd1 || m_seq_len !== 6'd2) begin
      bad++;
      $display("FAIL round2_status: score=%0d seq_len=%0d required 1/2", m_score, m_seq_len);
    end
    wait_player_turn();
    play_key(2'd3);
    play_key(2'd1);
    total++;
    if (m_score !== 6'd2 || m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL round2_done: score=%0d game_over=%0b required 2/0", m_score, m_game_over);
    end
  endtask

  task automatic test_wrong_press();
    use_w  = 1'b0;
    do_reset();
    rand_v = 2'd3;
    pulse_start();
    wait_lamp(2'd3);
    rand_v = 2'd1;
    wait_player_turn();
    play_key(2'd3);
    wait_lamp(2'd3);
    wait_lamp(2'd1);
    wait_player_turn();
    play_key(2'd3);
    total++;
    if (m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL good_first_key: game_over=%0b required 0", m_game_over);
    end
    player_key   = 2'd2;
    player_press = 1'b1;
    tick();
    player_press = 1'b0;
    tick();
    total++;
    if (m_game_over !== 1'b1) begin
      bad++;
      $display("FAIL wrong_key_lose: game_over=%0b required 1", m_game_over);
    end
    play_key(2'd1);
    play_key(2'd3);
    repeat (5) tick();
    total++;
    if (m_game_over !== 1'b1 || m_score !== 6'd1 || m_win !== 1'b0 || m_turn !== 1'b0) begin
      bad++;
      $display("FAIL lose_hold: game_over=%0b score=%0d win=%0b turn=%0b required 1/1/0/0",
               m_game_over, m_score, m_win, m_turn);
    end
  endtask

  task automatic test_holdover();
    use_w  = 1'b0;
    do_reset();
    rand_v = 2'd2;
    pulse_start();
    wait_lamp(2'd2);
    player_key   = 2'd1;
    player_press = 1'b1;
    wait_player_turn();
    repeat (5) tick();
    total++;
    if (m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL held_press_ignored: game_over=%0b required 0", m_game_over);
    end
    player_press = 1'b0;
    tick();
    tick();
    play_key(2'd2);
    total++;
    if (m_score !== 6'd1 || m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL press_after_release: score=%0d game_over=%0b required 1/0", m_score, m_game_over);
    end
  endtask

  task automatic test_timeout();
    use_w  = 1'b0;
    do_reset();
    rand_v = 2'd1;
    pulse_start();
    wait_lamp(2'd1);
    wait_player_turn();
    repeat (298) tick();
    total++;
    if (m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early_300: game_over=%0b required 0", m_game_over);
    end
    tick();
    total++;
    if (m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early_301: game_over=%0b required 0", m_game_over);
    end
    tick();
    total++;
    if (m_game_over !== 1'b1) begin
      bad++;
      $display("FAIL timeout_lose: game_over=%0b required 1", m_game_over);
    end

    do_reset();
    rand_v = 2'd1;
    pulse_start();
    wait_lamp(2'd1);
    wait_player_turn();
    repeat (298) tick();
    play_key(2'd1);
    tick();
    total++;
    if (m_game_over !== 1'b0 || m_score !== 6'd1) begin
      bad++;
      $display("FAIL press_at_expiry: game_over=%0b score=%0d required 0/1", m_game_over, m_score);
    end
  endtask

  task automatic test_win();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd0;
    exp_seq[1] = 2'd1;
    exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd0;
    use_w  = 1'b1;
    do_reset();
    rand_v = 2'd3;
    pulse_start();
    repeat (5) tick();
    total++;
    if (m_turn !== 1'b1 || m_seq_len !== 6'd0 || m_pressed !== 1'b0) begin
      bad++;
      $display("FAIL reject_first: turn=%0b seq_len=%0d pressed=%0b required 1/0/0",
               m_turn, m_seq_len, m_pressed);
    end
    rand_v = exp_seq[0];
    for (int r = 1; r <= 4; r++) begin
      for (int i = 0; i < r; i++) wait_lamp(exp_seq[i]);
      wait_player_turn();
      rand_v = 2'd3;
      for (int i = 0; i < r; i++) play_key(exp_seq[i]);
      if (r < 4) begin
        repeat (3) tick();
        total++;
        if (m_seq_len !== 6'(r) || m_turn !== 1'b1) begin
          bad++;
          $display("FAIL reject_round%0d: seq_len=%0d turn=%0b required %0d/1", r, m_seq_len, m_turn, r);
        end
        rand_v = exp_seq[r];
      end
    end
    total++;
    if (m_win !== 1'b1 || m_score !== 6'd4 || m_game_over !== 1'b0) begin
      bad++;
      $display("FAIL win_state: win=%0b score=%0d game_over=%0b required 1/4/0", m_win, m_score, m_game_over);
    end
    rand_v = 2'd1;
    pulse_start();
    wait_lamp(2'd1);
    total++;
    if (m_win !== 1'b0 || m_seq_len !== 6'd1 || m_score !== 6'd0) begin
      bad++;
      $display("FAIL win_restart: win=%0b seq_len=%0d score=%0d required 0/1/0", m_win, m_seq_len, m_score);
    end
  endtask

  initial begin
    use_w        = 1'b0;
    reset        = 1'b1;
    start        = 1'b0;
    rand_v       = 2'd0;
    player_key   = 2'd0;
    player_press = 1'b0;
    test_reset();
    test_rounds();
    test_wrong_press();
    test_holdover();
    test_timeout();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
